// File: rtl/irq_encoder.sv
// -----------------------------------------------------------------------------
// irq_encoder
//
// Four-line priority interrupt encoder. It latches requests into a pending
// register, presents the best eligible request to the CPU, and tracks the
// handlers currently running in an in-service register.
// Line 3 has the highest priority and line 0 the lowest.
//
// Parameters
//   TRIG_EDGE    1 = a rising edge on in_req[i] sets pending[i]
//                0 = a high level on in_req[i] sets pending[i] every cycle
//
// Compile-time option
//   IRQ_NEST_EN  when defined, a pending line is eligible if it is above the
//                highest in-service line, which allows nested preemption.
//                When undefined, a line is eligible only while nothing is
//                in service.
//
// Ports
//   in_clk       clock; all state changes on its rising edge
//   in_rst       synchronous active-high reset
//   in_req[3:0]  interrupt request lines
//   in_ie        global interrupt enable from the CPU
//   in_ack       one-cycle pulse: the CPU accepts the presented interrupt
//   in_eret      one-cycle pulse: the CPU returns from a handler
//   out_irq      registered interrupt request to the CPU
//   out_code     registered index of the presented interrupt
//   out_pending  pending register
//   out_insvc    in-service register
// -----------------------------------------------------------------------------
module irq_encoder #(
    parameter int TRIG_EDGE = 1
) (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic [3:0] in_req,
    input  logic       in_ie,
    input  logic       in_ack,
    input  logic       in_eret,
    output logic       out_irq,
    output logic [1:0] out_code,
    output logic [3:0] out_pending,
    output logic [3:0] out_insvc
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [3:0] prev;
    logic [3:0] pending;
    logic [3:0] insvc;
    logic [3:0] pending_next;
    logic [3:0] insvc_next;

    logic       irq_next;
    logic [1:0] code_next;

    logic [3:0] set_vec;
    logic [3:0] eligible;
    logic       cand_valid;
    logic [1:0] cand;

    logic       ack_fire;
    logic [3:0] ack_mask;
    logic [3:0] eret_mask;

    generate
        if (TRIG_EDGE != 0) begin : g_edge
            assign set_vec = in_req & ~prev;
        end else begin : g_level
            assign set_vec = in_req;
        end
    endgenerate

`ifdef IRQ_NEST_EN
    // A line is eligible when no in-service bit sits at or above its index.
    // This also covers the empty in-service case.
    always_comb begin
        eligible = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            eligible[i] = ((insvc >> i) == 4'b0000);
        end
    end
`else
    assign eligible = (insvc == 4'b0000) ? 4'b1111 : 4'b0000;
`endif

    // Ascending scan: the last eligible pending hit is the highest index.
    always_comb begin
        cand_valid = 1'b0;
        cand       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (pending[i] && eligible[i]) begin
                cand_valid = 1'b1;
                cand       = 2'(i);
            end
        end
    end

    // Return from a handler retires the highest in-service line.
    always_comb begin
        eret_mask = 4'b0000;
        if (in_eret) begin
            if (insvc[3]) begin
                eret_mask = 4'b1000;
            end else if (insvc[2]) begin
                eret_mask = 4'b0100;
            end else if (insvc[1]) begin
                eret_mask = 4'b0010;
            end else if (insvc[0]) begin
                eret_mask = 4'b0001;
            end
        end
    end

    // An ack only counts while a code is being presented.
    assign ack_fire = (state == PRESENT) && in_ack;
    assign ack_mask = ack_fire ? (4'b0001 << out_code) : 4'b0000;

    // The set term is ORed in last, so a new request wins over the ack clear.
    assign pending_next = (pending & ~ack_mask) | set_vec;

    // Eret clears a bit of the pre-edge in-service value, and ack sets a bit.
    // Both can take effect on the same edge.
    assign insvc_next = (insvc & ~eret_mask) | ack_mask;

    always_comb begin
        state_next = state;
        irq_next   = out_irq;
        code_next  = out_code;
        case (state)
            IDLE: begin
                if (in_ie && cand_valid) begin
                    state_next = PRESENT;
                    irq_next   = 1'b1;
                    code_next  = cand;
                end
            end
            PRESENT: begin
                // out_code is frozen here. A CPU accept or a dropped enable
                // ends the presentation.
                if (in_ack || !in_ie) begin
                    state_next = IDLE;
                    irq_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                irq_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state    <= IDLE;
            prev     <= 4'b0000;
            pending  <= 4'b0000;
            insvc    <= 4'b0000;
            out_irq  <= 1'b0;
            out_code <= 2'd0;
        end else begin
            state    <= state_next;
            prev     <= in_req;
            pending  <= pending_next;
            insvc    <= insvc_next;
            out_irq  <= irq_next;
            out_code <= code_next;
        end
    end

    assign out_pending = pending;
    assign out_insvc   = insvc;

endmodule

// File: tb/tb_irq_encoder.sv
// -----------------------------------------------------------------------------
// tb_irq_encoder
//
// Self-checking bench for irq_encoder. It runs one edge-triggered instance and
// one level-triggered instance side by side on the same inputs.
// A behavioural reference model predicts
// {out_irq, out_code, out_pending, out_insvc} for each instance.
// The directed tasks also check hand-derived constant vectors.
// The bench honours IRQ_NEST_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_irq_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ie;
    logic       ack;
    logic       eret;

    logic       irq_e;
    logic [1:0] code_e;
    logic [3:0] pend_e;
    logic [3:0] insvc_e;

    logic       irq_l;
    logic [1:0] code_l;
    logic [3:0] pend_l;
    logic [3:0] insvc_l;

    logic [10:0] obs_e;
    logic [10:0] obs_l;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: index 0 is the edge instance, index 1 the level one.
    logic [3:0] m_prev  [2];
    logic [3:0] m_pend  [2];
    logic [3:0] m_insvc [2];
    logic       m_busy  [2];
    logic [1:0] m_code  [2];

    always #5 clk = ~clk;

    irq_encoder #(.TRIG_EDGE(1)) dut_edge (
        .in_clk      (clk),
        .in_rst      (rst),
        .in_req      (req),
        .in_ie       (ie),
        .in_ack      (ack),
        .in_eret     (eret),
        .out_irq     (irq_e),
        .out_code    (code_e),
        .out_pending (pend_e),
        .out_insvc   (insvc_e)
    );

    irq_encoder #(.TRIG_EDGE(0)) dut_level (
        .in_clk      (clk),
        .in_rst      (rst),
        .in_req      (req),
        .in_ie       (ie),
        .in_ack      (ack),
        .in_eret     (eret),
        .out_irq     (irq_l),
        .out_code    (code_l),
        .out_pending (pend_l),
        .out_insvc   (insvc_l)
    );

    assign obs_e = {irq_e, code_e, pend_e, insvc_e};
    assign obs_l = {irq_l, code_l, pend_l, insvc_l};

    function automatic int top_bit(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit is_eligible(input int idx, input logic [3:0] svc);
`ifdef IRQ_NEST_EN
        return idx > top_bit(svc);
`else
        return svc == 4'b0000;
`endif
    endfunction

    function automatic logic [10:0] exp_vec(input int k);
        return {m_busy[k], m_code[k], m_pend[k], m_insvc[k]};
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] set_bits;
            logic [3:0] nxt_pend;
            logic [3:0] nxt_insvc;
            int         cand;
            int         top;
            if (rst) begin
                m_prev[k]  = 4'b0000;
                m_pend[k]  = 4'b0000;
                m_insvc[k] = 4'b0000;
                m_busy[k]  = 1'b0;
                m_code[k]  = 2'd0;
            end else begin
                set_bits  = (k == 0) ? (req & ~m_prev[k]) : req;
                nxt_pend  = m_pend[k];
                nxt_insvc = m_insvc[k];
                top       = top_bit(m_insvc[k]);
                if (eret && top >= 0) nxt_insvc[top] = 1'b0;
                if (m_busy[k] && ack) begin
                    nxt_pend[m_code[k]]  = 1'b0;
                    nxt_insvc[m_code[k]] = 1'b1;
                end
                nxt_pend = nxt_pend | set_bits;
                if (!m_busy[k]) begin
                    cand = -1;
                    for (int i = 0; i < 4; i++) begin
                        if (m_pend[k][i] && is_eligible(i, m_insvc[k])) cand = i;
                    end
                    if (ie && cand >= 0) begin
                        m_busy[k] = 1'b1;
                        m_code[k] = 2'(cand);
                    end
                end else if (ack || !ie) begin
                    m_busy[k] = 1'b0;
                end
                m_pend[k]  = nxt_pend;
                m_insvc[k] = nxt_insvc;
                m_prev[k]  = req;
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic apply_stimulus(input logic r, input logic [3:0] rq,
                                  input logic e, input logic a, input logic er);
        @(negedge clk);
        rst  = r;
        req  = rq;
        ie   = e;
        ack  = a;
        eret = er;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] want;
        want = 11'd0;
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            n_cmp++;
            if (obs_e !== want) begin n_bad++; $display("[TB] FAIL reset_edge obs=%b exp=%b", obs_e, want); end
            n_cmp++;
            if (obs_l !== want) begin n_bad++; $display("[TB] FAIL reset_level obs=%b exp=%b", obs_l, want); end
        end
    endtask

    task automatic test_basic();
        logic [10:0] want;
        apply_stimulus(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        want = {1'b0, 2'd0, 4'b0100, 4'b0000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL basic_pending obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        want = {1'b1, 2'd2, 4'b0100, 4'b0000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL basic_present obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        want = {1'b0, 2'd2, 4'b0000, 4'b0100}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL basic_ack obs=%b exp=%b", obs_e, want); end
    endtask

    task automatic test_priority();
        logic [10:0] want;
        apply_stimulus(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b1001, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        want = {1'b1, 2'd3, 4'b1001, 4'b0000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL prio_first obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        want = {1'b0, 2'd3, 4'b0001, 4'b1000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL prio_ack obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
        want = {1'b0, 2'd3, 4'b0001, 4'b0000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL prio_eret obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        want = {1'b1, 2'd0, 4'b0001, 4'b0000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL prio_second obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        want = {1'b0, 2'd0, 4'b0000, 4'b0001}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL prio_ack2 obs=%b exp=%b", obs_e, want); end
    endtask

    task automatic test_hold();
        logic [10:0] want;
        apply_stimulus(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
        want = {1'b1, 2'd1, 4'b1010, 4'b0000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL hold_code obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        want = {1'b1, 2'd1, 4'b1010, 4'b0000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL hold_code2 obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        want = {1'b0, 2'd1, 4'b1000, 4'b0010}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL hold_ack obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
`ifdef IRQ_NEST_EN
        want = {1'b1, 2'd3, 4'b1000, 4'b0010}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL hold_nest obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        want = {1'b0, 2'd3, 4'b0000, 4'b1010}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL hold_nest_ack obs=%b exp=%b", obs_e, want); end
`else
        want = {1'b0, 2'd1, 4'b1000, 4'b0010}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL hold_wait obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        want = {1'b1, 2'd3, 4'b1000, 4'b0000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL hold_after_eret obs=%b exp=%b", obs_e, want); end
`endif
    endtask

    task automatic test_withdraw();
        logic [10:0] want;
        apply_stimulus(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
        want = {1'b0, 2'd2, 4'b0100, 4'b0000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL withdraw_drop obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        want = {1'b1, 2'd2, 4'b0100, 4'b0000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL withdraw_again obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        want = {1'b0, 2'd2, 4'b0000, 4'b0100}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL withdraw_ack obs=%b exp=%b", obs_e, want); end
    endtask

    task automatic test_collision();
        logic [10:0] want;
        apply_stimulus(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0);
        want = {1'b0, 2'd2, 4'b0100, 4'b0100}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL set_beats_ack obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
`ifdef IRQ_NEST_EN
        want = {1'b1, 2'd3, 4'b1000, 4'b0100}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL nest_present obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
        want = {1'b0, 2'd3, 4'b0000, 4'b1000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL eret_and_ack obs=%b exp=%b", obs_e, want); end
`else
        want = {1'b0, 2'd2, 4'b1000, 4'b0100}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL no_nest_wait obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);
        want = {1'b0, 2'd2, 4'b1000, 4'b0000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL idle_ack_ignored obs=%b exp=%b", obs_e, want); end
`endif
    endtask

    task automatic test_reset_present();
        logic [10:0] want;
        apply_stimulus(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
`ifdef IRQ_NEST_EN
        want = {1'b1, 2'd2, 4'b0100, 4'b0011};
`else
        want = {1'b0, 2'd0, 4'b0110, 4'b0001};
`endif
        n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL pre_reset obs=%b exp=%b", obs_e, want); end
        apply_stimulus(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
        want = 11'd0; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL reset_abandon_edge obs=%b exp=%b", obs_e, want); end
        n_cmp++;
        if (obs_l !== want) begin n_bad++; $display("[TB] FAIL reset_abandon_level obs=%b exp=%b", obs_l, want); end
        // A high line right after reset must count as an edge.
        apply_stimulus(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        want = {1'b0, 2'd0, 4'b1111, 4'b0000}; n_cmp++;
        if (obs_e !== want) begin n_bad++; $display("[TB] FAIL prev_cleared obs=%b exp=%b", obs_e, want); end
    endtask

    task automatic test_level();
        logic [10:0] want;
        apply_stimulus(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
        want = {1'b1, 2'd2, 4'b0100, 4'b0000}; n_cmp++;
        if (obs_l !== want) begin n_bad++; $display("[TB] FAIL level_present obs=%b exp=%b", obs_l, want); end
        for (int c = 0; c < 2; c++) begin
            apply_stimulus(1'b0, 4'b0100, 1'b1, (c == 0) ? 1'b1 : 1'b0, 1'b0);
            want = {1'b0, 2'd2, 4'b0100, 4'b0100}; n_cmp++;
            if (obs_l !== want) begin n_bad++; $display("[TB] FAIL level_reset_pending obs=%b exp=%b", obs_l, want); end
            want = {1'b0, 2'd2, 4'b0000, 4'b0100}; n_cmp++;
            if (obs_e !== want) begin n_bad++; $display("[TB] FAIL edge_held_line obs=%b exp=%b", obs_e, want); end
        end
    endtask

    task automatic test_random();
        logic [10:0] want;
        for (int c = 0; c < 3000; c++) begin
            apply_stimulus(($urandom_range(0, 99) == 0),
                           4'($urandom) & 4'($urandom),
                           ($urandom_range(0, 9) != 0),
                           ($urandom_range(0, 9) < 4),
                           ($urandom_range(0, 99) < 15));
            want = exp_vec(0); n_cmp++;
            if (obs_e !== want) begin n_bad++; $display("[TB] FAIL rand_edge cyc=%0d obs=%b exp=%b", c, obs_e, want); end
            want = exp_vec(1); n_cmp++;
            if (obs_l !== want) begin n_bad++; $display("[TB] FAIL rand_level cyc=%0d obs=%b exp=%b", c, obs_l, want); end
        end
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        ie   = 1'b0;
        ack  = 1'b0;
        eret = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_prev[k]  = 4'b0000;
            m_pend[k]  = 4'b0000;
            m_insvc[k] = 4'b0000;
            m_busy[k]  = 1'b0;
            m_code[k]  = 2'd0;
        end
        $display("[TB] irq_encoder bench starting");
        test_reset();
        test_basic();
        test_priority();
        test_hold();
        test_withdraw();
        test_collision();
        test_reset_present();
        test_level();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
